// File: rtl/ex_mem_flag_stage.sv
// rtl/ex_mem_flag_stage.sv - EX/MEM boundary register with Z/V/N flag register and HLT tracking
//
// Purpose:
//   Captures the ALU result, write-back info and the destination register at the EX/MEM
//   boundary. Owns the architectural Z/V/N flag register. Tracks HLT retirement with a
//   RUN -> DRAIN -> HALTED state machine.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, stall, flush   EX stage qualifiers
//   opcode, alu_res,         EX instruction, ALU (saturated) result, adder overflow,
//   alu_ovfl, wr_en, dst     write enable and destination register
//   out_valid, out_res,      registered EX/MEM contents; out_wr is 0 whenever out_valid is 0
//   out_wr, out_dst
//   flag_z, flag_v, flag_n   architectural flags
//   flag_fwd                 {N,V,Z} as seen by the branch unit
//   halted                   HLT has retired from this stage
//
// Configuration:
//   FLAG_BYPASS_EN  when defined, flag_fwd carries the flags the current EX instruction
//                   would produce if it advances this cycle (combinational bypass).
//                   When undefined, flag_fwd is the registered flag value.

module ex_mem_flag_stage #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_ovfl,
  input  logic             wr_en,
  input  logic [REGW-1:0]  dst,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_res,
  output logic             out_wr,
  output logic [REGW-1:0]  out_dst,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic [2:0]       flag_fwd,
  output logic             halted
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR = OPW'(6);
  localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             wr_q,    wr_d;
  logic [REGW-1:0]  dst_q,   dst_d;
  logic             z_q,     z_d;
  logic             v_q,     v_d;
  logic             n_q,     n_d;

  logic             advance;
  logic             z_upd, v_upd, n_upd;

  assign advance = in_valid & ~stall & ~flush & (state_q == S_RUN);

  // Flags the EX instruction would leave behind if it advanced. Z is taken on the
  // saturated result, so a clamped 0x7FFF/0x8000 never reports zero.
  always_comb begin
    z_upd = z_q;
    v_upd = v_q;
    n_upd = n_q;
    case (opcode)
      OP_ADD, OP_SUB: begin
        z_upd = (alu_res == '0);
        v_upd = alu_ovfl;
        n_upd = alu_res[WIDTH-1];
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        z_upd = (alu_res == '0);
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    wr_d    = wr_q;
    dst_d   = dst_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    case (state_q)
      S_RUN: begin
        if (flush || (!stall && !in_valid)) begin
          valid_d = 1'b0;
          wr_d    = 1'b0;
        end else if (advance) begin
          valid_d = 1'b1;
          res_d   = alu_res;
          dst_d   = dst;
          wr_d    = wr_en;
          z_d     = z_upd;
          v_d     = v_upd;
          n_d     = n_upd;
          if (opcode == OP_HLT) begin
            // HLT occupies out_* for one cycle but never writes the register file.
            wr_d    = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // A stall keeps HLT visible downstream; a flush cannot cancel the halt.
        if (flush || !stall) begin
          valid_d = 1'b0;
          wr_d    = 1'b0;
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
        wr_d    = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        wr_d    = 1'b0;
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      dst_q   <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      dst_q   <= dst_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_wr    = wr_q;
  assign out_dst   = dst_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign halted    = (state_q == S_HALTED);

`ifdef FLAG_BYPASS_EN
  assign flag_fwd = advance ? {n_upd, v_upd, z_upd} : {n_q, v_q, z_q};
`else
  assign flag_fwd = {n_q, v_q, z_q};
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb/tb_ex_mem_flag_stage.sv - self-checking bench for ex_mem_flag_stage
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, alu_ovfl, wr_en;
  logic [3:0]  opcode, dst;
  logic [15:0] alu_res;
  logic        out_valid, out_wr, flag_z, flag_v, flag_n, halted;
  logic [15:0] out_res;
  logic [3:0]  out_dst;
  logic [2:0]  flag_fwd;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed in the stage's architectural terms.
  logic        m_valid, m_wr, m_z, m_v, m_n;
  logic [15:0] m_res;
  logic [3:0]  m_dst;
  bit          m_hlt_pending;  // HLT sits in out_* and has not yet retired
  bit          m_halted;

  always #5 clk = ~clk;

  ex_mem_flag_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .alu_res(alu_res), .alu_ovfl(alu_ovfl), .wr_en(wr_en), .dst(dst),
    .out_valid(out_valid), .out_res(out_res), .out_wr(out_wr), .out_dst(out_dst),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .flag_fwd(flag_fwd), .halted(halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic iv, input logic st, input logic fl,
                        input logic [3:0] op, input logic [15:0] res, input logic ov,
                        input logic we, input logic [3:0] d);
    rst = r; in_valid = iv; stall = st; flush = fl;
    opcode = op; alu_res = res; alu_ovfl = ov; wr_en = we; dst = d;
  endtask

  function automatic bit model_advance();
    return in_valid && !stall && !flush && !m_hlt_pending && !m_halted;
  endfunction

  // Flags produced by the instruction currently in EX, by opcode class.
  function automatic logic [2:0] model_new_flags();
    logic z, v, n;
    z = m_z; v = m_v; n = m_n;
    if (opcode == 4'd0 || opcode == 4'd1) begin
      z = (alu_res == 16'd0); v = alu_ovfl; n = alu_res[15];
    end else if (opcode == 4'd2 || opcode == 4'd4 || opcode == 4'd5 || opcode == 4'd6) begin
      z = (alu_res == 16'd0);
    end
    return {n, v, z};
  endfunction

  task automatic model_edge();
    logic [2:0] nf;
    if (rst) begin
      m_valid = 0; m_wr = 0; m_res = 0; m_dst = 0;
      m_z = 0; m_v = 0; m_n = 0; m_hlt_pending = 0; m_halted = 0;
    end else if (m_halted) begin
      m_valid = 0; m_wr = 0;
    end else if (m_hlt_pending) begin
      if (flush || !stall) begin
        m_valid = 0; m_wr = 0; m_hlt_pending = 0; m_halted = 1;
      end
    end else if (flush) begin
      m_valid = 0; m_wr = 0;
    end else if (stall) begin
      // everything holds
    end else if (!in_valid) begin
      m_valid = 0; m_wr = 0;
    end else begin
      nf = model_new_flags();
      m_valid = 1; m_res = alu_res; m_dst = dst; m_wr = wr_en;
      {m_n, m_v, m_z} = nf;
      if (opcode == 4'd15) begin
        m_wr = 0; m_hlt_pending = 1;
      end
    end
  endtask

  task automatic tick();
    logic [2:0] efwd;
    #1;
`ifdef FLAG_BYPASS_EN
    efwd = model_advance() ? model_new_flags() : {m_n, m_v, m_z};
`else
    efwd = {m_n, m_v, m_z};
`endif
    chk("flag_fwd", {13'd0, flag_fwd}, {13'd0, efwd});
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
    chk("out_res", out_res, m_res);
    chk("out_wr", {15'd0, out_wr}, {15'd0, m_wr});
    chk("out_dst", {12'd0, out_dst}, {12'd0, m_dst});
    chk("flags_nvz", {13'd0, flag_n, flag_v, flag_z}, {13'd0, m_n, m_v, m_z});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
  endtask

  initial begin
    m_valid = 0; m_wr = 0; m_res = 0; m_dst = 0;
    m_z = 0; m_v = 0; m_n = 0; m_hlt_pending = 0; m_halted = 0;

    // 1: reset with random inputs
    set_in(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom));
    tick();
    set_in(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom));
    tick();
    chk("t1_reset_all", {out_valid, out_wr, halted, flag_z, flag_v, flag_n, out_res[9:0]}, 16'd0);

    // 2: ADD zero then SUB 0x8000 with overflow
    set_in(0, 1, 0, 0, 4'd0, 16'h0000, 0, 1, 4'd3);
    tick();
    chk("t2_add_znv", {13'd0, flag_z, flag_v, flag_n}, 16'b100);
    set_in(0, 1, 0, 0, 4'd1, 16'h8000, 1, 1, 4'd4);
    tick();
    chk("t2_sub_znv", {13'd0, flag_z, flag_v, flag_n}, 16'b011);

    // 3: XOR 0 -> Z=1,V=1,N=1; XOR 5 clears Z only; PADDSB leaves flags alone
    set_in(0, 1, 0, 0, 4'd2, 16'h0000, 0, 1, 4'd5);
    tick();
    chk("t3_all_set", {13'd0, flag_z, flag_v, flag_n}, 16'b111);
    set_in(0, 1, 0, 0, 4'd2, 16'h0005, 0, 1, 4'd5);
    tick();
    chk("t3_xor_znv", {13'd0, flag_z, flag_v, flag_n}, 16'b011);
    set_in(0, 1, 0, 0, 4'd7, 16'h0000, 1, 1, 4'd6);
    tick();
    chk("t3_paddsb_znv", {13'd0, flag_z, flag_v, flag_n}, 16'b011);

    // 4: ADD 0x1234 stalled three cycles, then released
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 0, 4'd0, 16'h1234, 0, 1, 4'd7);
      tick();
    end
    chk("t4_stall_hold", out_res, 16'h0000);
    set_in(0, 1, 0, 0, 4'd0, 16'h1234, 0, 1, 4'd7);
    tick();
    chk("t4_release", out_res, 16'h1234);

    // 5: SUB 0 flushed while stalled
    set_in(0, 1, 1, 1, 4'd1, 16'h0000, 0, 1, 4'd8);
    tick();
    chk("t5_flush", {14'd0, out_valid, out_wr}, 16'd0);
    chk("t5_z_hold", {15'd0, flag_z}, 16'd0);

    // 6: HLT drains then halts; later instruction ignored; reset recovers
    set_in(0, 1, 0, 0, 4'd15, 16'h00AA, 0, 1, 4'd9);
    tick();
    chk("t6_drain", {14'd0, out_valid, out_wr}, 16'b10);
    set_in(0, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 4'd0);
    tick();
    chk("t6_halted", {15'd0, halted}, 16'd1);
    set_in(0, 1, 0, 0, 4'd0, 16'h0000, 0, 1, 4'd2);
    tick();
    chk("t6_ignored", {15'd0, out_valid}, 16'd0);
    set_in(1, 1, 0, 0, 4'd0, 16'h0000, 0, 1, 4'd2);
    tick();
    chk("t6_reset", {15'd0, halted}, 16'd0);
    set_in(0, 1, 0, 0, 4'd0, 16'h0000, 0, 1, 4'd2);
    tick();

    // Randomized traffic against the model, including HLT, stalls, flushes and resets
    for (int i = 0; i < 500; i++) begin
      set_in(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
             1'($urandom), 1'($urandom), 4'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
